// File: rtl/div_pkg.sv
// Shared definitions for the serial divider sequencer beside EX: state
// encodings, handshake levels and bus widths.
package div_pkg;

  localparam int unsigned RegBus       = 32;
  localparam int unsigned DoubleRegBus = 64;
  localparam int unsigned CntW         = 6;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResReady    = 1'b1;
  localparam logic DivResNotReady = 1'b0;
  localparam logic DivStart       = 1'b1;
  localparam logic DivStop        = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   i_work    : {partial remainder (DATA_W+1), quotient (DATA_W)} working word
//   i_divisor : divisor magnitude
//   o_work    : working word after shift, trial subtract and quotient-bit set
module div_step
  import div_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus
) (
  input  logic [2*DATA_W:0] i_work,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [2*DATA_W:0] o_work
);

  logic [2*DATA_W:0] w_shift;
  logic [DATA_W:0]   w_diff;
  // The partial remainder never reaches the top bit before the shift.
  logic              w_unused_msb;

  assign w_unused_msb = i_work[2*DATA_W];
  assign w_shift      = {i_work[2*DATA_W-1:0], 1'b0};
  assign w_diff       = w_shift[2*DATA_W:DATA_W] - {1'b0, i_divisor};

  // Keep the difference only when it did not borrow.
  always_comb begin
    o_work = w_shift;
    if (!w_diff[DATA_W]) begin
      o_work = {w_diff, w_shift[DATA_W-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle serial divider for DIV/DIVU. Returns {remainder, quotient}.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   signed_div_i  : 1 = signed, 0 = unsigned; sampled with start in FREE
//   op1_i, op2_i  : dividend, divisor; sampled when the op launches
//   start_i       : request, held high by EX for the whole operation
//   annul_i       : abort request (ignored once the result is ready)
//   result_o      : {remainder, quotient}; zero unless ready_o
//   ready_o       : result valid
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     op1_i,
  input  logic [DATA_W-1:0]     op2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  div_state_e          r_state;
  logic [CntW-1:0]     r_cnt;
  logic [2*DATA_W:0]   r_work;
  logic [DATA_W-1:0]   r_div;
  logic                r_signed;
  logic                r_dsign;
  logic                r_qneg;

  logic [DATA_W-1:0]   w_op1_mag;
  logic [DATA_W-1:0]   w_op2_mag;
  logic [2*DATA_W:0]   w_next;
  logic [DATA_W-1:0]   w_q;
  logic [DATA_W-1:0]   w_r;
  logic [DATA_W-1:0]   w_q_fix;
  logic [DATA_W-1:0]   w_r_fix;
  logic                w_go;

  assign w_go = (start_i == DivStart) && !annul_i;

  // Operand magnitudes; INT_MIN negates to itself, which is correct unsigned.
  assign w_op1_mag = (signed_div_i && op1_i[DATA_W-1]) ? (DATA_W'(0) - op1_i) : op1_i;
  assign w_op2_mag = (signed_div_i && op2_i[DATA_W-1]) ? (DATA_W'(0) - op2_i) : op2_i;

  div_step #(.DATA_W(DATA_W)) u_step (
    .i_work    (r_work),
    .i_divisor (r_div),
    .o_work    (w_next)
  );

  // Sign fixup applied to the last iteration's output; remainder follows dividend.
  assign w_q     = w_next[DATA_W-1:0];
  assign w_r     = w_next[2*DATA_W-1:DATA_W];
  assign w_q_fix = r_qneg ? (DATA_W'(0) - w_q) : w_q;
  assign w_r_fix = (r_signed && r_dsign) ? (DATA_W'(0) - w_r) : w_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DivFree;
      r_cnt    <= '0;
      r_work   <= '0;
      r_div    <= '0;
      r_signed <= 1'b0;
      r_dsign  <= 1'b0;
      r_qneg   <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          ready_o  <= DivResNotReady;
          result_o <= '0;
          if (w_go) begin
            if (op2_i == '0) begin
              r_state <= DivByZero;
            end else begin
              r_div    <= w_op2_mag;
              r_signed <= signed_div_i;
              r_dsign  <= op1_i[DATA_W-1];
              r_qneg   <= signed_div_i & (op1_i[DATA_W-1] ^ op2_i[DATA_W-1]);
              r_work   <= {(DATA_W+1)'(0), w_op1_mag};
              r_cnt    <= '0;
              r_state  <= DivOn;
            end
          end
        end

        DivByZero: begin
          if (w_go) begin
            r_work  <= '0;
            r_state <= DivEnd;
          end else begin
            r_state <= DivFree;
          end
        end

        DivOn: begin
          if (!w_go) begin
            r_work  <= '0;
            r_cnt   <= '0;
            r_state <= DivFree;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
            if (r_cnt == CntW'(DATA_W - 1)) begin
              r_work  <= {1'b0, w_r_fix, w_q_fix};
              r_state <= DivEnd;
            end else begin
              r_work <= w_next;
            end
          end
        end

        DivEnd: begin
          // Result is presented one edge after entering END and held while start stays high.
          if (start_i == DivStart) begin
            ready_o  <= DivResReady;
            result_o <= r_work[2*DATA_W-1:0];
          end else begin
            ready_o  <= DivResNotReady;
            result_o <= '0;
            r_state  <= DivFree;
          end
        end

        default: r_state <= DivFree;
      endcase
    end
  end

endmodule
